// File: rtl/mem_stage.sv
`default_nettype none
// ============================================================================
//  Module      : mem_stage
//  Description : Memory-access pipeline stage. Completes the data request,
//                aligns/extends load data and forwards exception/CP0 fields.
//  Revision    : 1.0 - initial release
// ============================================================================
module mem_stage #(
    parameter int ES_TO_MS_BUS_WD = 132,
    parameter int MS_TO_WS_BUS_WD = 123
) (
    input  logic                       clk,
    input  logic                       reset,
    input  logic                       ws_allowin,
    output logic                       ms_allowin,
    input  logic                       es_to_ms_valid,
    input  logic [ES_TO_MS_BUS_WD-1:0] es_to_ms_bus,
    output logic                       ms_to_ws_valid,
    output logic [MS_TO_WS_BUS_WD-1:0] ms_to_ws_bus,
    input  logic                       data_sram_data_ok,
    input  logic [31:0]                data_sram_rdata,
    input  logic                       flush,
    output logic                       ms_ex,
    output logic                       ms_eret,
    output logic [31:0]                ms_forward_data,
    output logic [4:0]                 ms_dest,
    output logic                       ms_load_wait
);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        WAIT    = 2'd1,
        HELD    = 2'd2,
        DISCARD = 2'd3
    } state_t;

    state_t                     r_state;
    state_t                     w_state_nxt;
    logic                       r_ms_valid;
    logic [ES_TO_MS_BUS_WD-1:0] r_bus;
    logic [31:0]                r_buf;
    logic                       r_buf_valid;

    logic        w_store, w_lw, w_bd, w_ex, w_eret, w_mtc0, w_mfc0, w_res_from_mem;
    logic        w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr;
    logic [31:0] w_badvaddr, w_result, w_pc;
    logic [7:0]  w_c0_addr;
    logic [4:0]  w_excode, w_dest;
    logic [3:0]  w_bus_gr_we;

    assign w_store        = r_bus[131];
    assign w_lw           = r_bus[130];
    assign w_badvaddr     = r_bus[129:98];
    assign w_bd           = r_bus[97];
    assign w_c0_addr      = r_bus[96:89];
    assign w_ex           = r_bus[88];
    assign w_excode       = r_bus[87:83];
    assign w_eret         = r_bus[82];
    assign w_mtc0         = r_bus[81];
    assign w_mfc0         = r_bus[80];
    assign {w_lb, w_lbu, w_lh, w_lhu, w_lwl, w_lwr} = r_bus[79:74];
    assign w_res_from_mem = r_bus[73];
    assign w_bus_gr_we    = r_bus[72:69];
    assign w_dest         = r_bus[68:64];
    assign w_result       = r_bus[63:32];
    assign w_pc           = r_bus[31:0];

    logic w_need_mem, w_in_need_mem, w_ready_go, w_capture;

    // Excepting entries never issued a request, so they owe no response.
    assign w_need_mem    = (w_res_from_mem | w_store) & ~w_ex;
    assign w_in_need_mem = (es_to_ms_bus[73] | es_to_ms_bus[131]) & ~es_to_ms_bus[88];
    assign w_ready_go    = ~w_need_mem | ((r_state == WAIT) & data_sram_data_ok) | (r_state == HELD);
    assign ms_allowin    = (r_state != DISCARD) & (~r_ms_valid | (w_ready_go & ws_allowin));
    assign w_capture     = ms_allowin & es_to_ms_valid & ~flush;

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE: w_state_nxt = IDLE;
            WAIT: begin
                if (flush)
                    w_state_nxt = data_sram_data_ok ? IDLE : DISCARD;
                else if (data_sram_data_ok)
                    w_state_nxt = ws_allowin ? IDLE : HELD;
            end
            HELD:    if (flush || ws_allowin) w_state_nxt = IDLE;
            DISCARD: if (data_sram_data_ok)   w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // A newly accepted memory op always restarts the wait, even back-to-back.
        if (w_capture && w_in_need_mem)
            w_state_nxt = WAIT;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= IDLE;
            r_ms_valid  <= 1'b0;
            r_buf_valid <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_buf_valid <= (w_state_nxt == HELD);
            if (flush)
                r_ms_valid <= 1'b0;
            else if (ms_allowin)
                r_ms_valid <= es_to_ms_valid;
        end
    end

    always_ff @(posedge clk) begin
        if (w_capture)
            r_bus <= es_to_ms_bus;
        if ((r_state == WAIT) && (w_state_nxt == HELD))
            r_buf <= data_sram_rdata;
    end

    logic [31:0] w_word, w_final;
    logic [7:0]  w_byte;
    logic [15:0] w_half;
    logic [3:0]  w_gr_we;
    logic [1:0]  w_a;

    assign w_word = r_buf_valid ? r_buf : data_sram_rdata;
    assign w_a    = w_result[1:0];
    assign w_half = w_a[1] ? w_word[31:16] : w_word[15:0];

    always_comb begin
        case (w_a)
            2'd0:    w_byte = w_word[7:0];
            2'd1:    w_byte = w_word[15:8];
            2'd2:    w_byte = w_word[23:16];
            default: w_byte = w_word[31:24];
        endcase
    end

    always_comb begin
        w_final = w_result;
        w_gr_we = w_bus_gr_we;
        if (w_res_from_mem && !w_ex) begin
            if (w_lb)       w_final = {{24{w_byte[7]}}, w_byte};
            else if (w_lbu) w_final = {24'd0, w_byte};
            else if (w_lh)  w_final = {{16{w_half[15]}}, w_half};
            else if (w_lhu) w_final = {16'd0, w_half};
            else if (w_lwl) begin
                case (w_a)
                    2'd0:    begin w_final = {w_word[7:0], 24'd0};  w_gr_we = 4'b1000; end
                    2'd1:    begin w_final = {w_word[15:0], 16'd0}; w_gr_we = 4'b1100; end
                    2'd2:    begin w_final = {w_word[23:0], 8'd0};  w_gr_we = 4'b1110; end
                    default: begin w_final = w_word;                w_gr_we = 4'b1111; end
                endcase
            end else if (w_lwr) begin
                case (w_a)
                    2'd0:    begin w_final = w_word;                 w_gr_we = 4'b1111; end
                    2'd1:    begin w_final = {8'd0, w_word[31:8]};   w_gr_we = 4'b0111; end
                    2'd2:    begin w_final = {16'd0, w_word[31:16]}; w_gr_we = 4'b0011; end
                    default: begin w_final = {24'd0, w_word[31:24]}; w_gr_we = 4'b0001; end
                endcase
            end else if (w_lw) w_final = w_word;
            else               w_final = w_word;
        end
        if (w_ex)
            w_gr_we = 4'b0000;
    end

    assign ms_to_ws_valid  = r_ms_valid & w_ready_go & ~flush;
    assign ms_to_ws_bus    = r_ms_valid ? {w_badvaddr, w_bd, w_c0_addr, w_ex, w_excode, w_eret,
                                           w_mtc0, w_mfc0, w_gr_we, w_dest, w_final, w_pc}
                                        : '0;
    assign ms_ex           = r_ms_valid & w_ex;
    assign ms_eret         = r_ms_valid & w_eret;
    assign ms_forward_data = r_ms_valid ? w_final : 32'd0;
    assign ms_dest         = (r_ms_valid && (w_gr_we != 4'd0) && !w_ex) ? w_dest : 5'd0;
    assign ms_load_wait    = r_ms_valid & w_res_from_mem & ~w_ex & ~w_ready_go;

endmodule
`default_nettype wire
